// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: memory access codes, LSU FSM states,
// byte-enable constants and access-code helpers.
package riscv_pkg;

    // {is_store, funct3} as delivered by the control unit
    typedef enum logic [3:0] {
        MC_LB  = 4'b0000,
        MC_LH  = 4'b0001,
        MC_LW  = 4'b0010,
        MC_LBU = 4'b0100,
        MC_LHU = 4'b0101,
        MC_SB  = 4'b1000,
        MC_SH  = 4'b1001,
        MC_SW  = 4'b1010
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Direction comes from the request strobes (store wins when both
    // are high). A code that is undefined, or whose store bit disagrees
    // with that direction, falls back to a full-word access.
    function automatic mem_ctrl_t norm_ctrl(
        input logic       is_store,
        input logic [3:0] code
    );
        mem_ctrl_t c;
        c = is_store ? MC_SW : MC_LW;
        case (code)
            MC_LB, MC_LH, MC_LW, MC_LBU, MC_LHU,
            MC_SB, MC_SH, MC_SW: begin
                if (code[3] == is_store)
                    c = mem_ctrl_t'(code);
            end
            default: ;
        endcase
        return c;
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic misaligned(
        input mem_ctrl_t  c,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        case (c[1:0])
            2'b01:   m = lo[0];
            2'b10:   m = |lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
// Ports: st_size/st_off/st_data -> st_be/st_wdata (store lane
// replication and byte enables); ld_size/ld_uns/ld_off/ld_word ->
// ld_data (load lane extraction with sign/zero extension).
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        case (st_size)
            2'b00: begin
                st_be    = BE_BYTE << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                // addr[0] is dropped so a halfword stays in its pair
                st_be    = BE_HALF << {st_off[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_b    = ld_word[{ld_off, 3'b000} +: 8];
        ld_h    = ld_word[{ld_off[1], 4'b0000} +: 16];
        ld_data = ld_word;
        case (ld_size)
            2'b00:   ld_data = {{24{ld_b[7] & ~ld_uns}}, ld_b};
            2'b01:   ld_data = {{16{ld_h[15] & ~ld_uns}}, ld_h};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> (WAIT_R) -> DONE bus sequencer.
// In: clk, rst (async, active-high), mem_r, mem_w, mem_ctrl, addr,
//     wdata, bus_gnt, bus_rvalid, bus_rdata.
// Out: rdata, stall, misalign, bus_req, bus_we, bus_addr, bus_be,
//     bus_wdata.
// Define LSU_MISALIGN_TRAP_EN to flag and drop misaligned accesses;
// otherwise low address bits are truncated to natural alignment.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [3:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsu_state_t state, state_nx;
    mem_ctrl_t  in_ctrl, op_ctrl;
    logic [1:0] op_off;
    logic       access, mis, issue, capture;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign access  = mem_r | mem_w;
    assign in_ctrl = norm_ctrl(mem_w, mem_ctrl);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = access & misaligned(in_ctrl, addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign issue = (state == IDLE) & access & ~mis;

    // Load data lands either with the grant or later in WAIT_R
    assign capture = bus_rvalid & ~op_ctrl[3] &
                     (((state == REQ) & bus_gnt) | (state == WAIT_R));

    lsu_align u_align (
        .st_size  (in_ctrl[1:0]),
        .st_off   (addr[1:0]),
        .st_data  (wdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_size  (op_ctrl[1:0]),
        .ld_uns   (op_ctrl[2]),
        .ld_off   (op_off),
        .ld_word  (bus_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (issue) state_nx = REQ;
            REQ: begin
                if (bus_gnt)
                    state_nx = (op_ctrl[3] | bus_rvalid) ? DONE : WAIT_R;
            end
            WAIT_R: if (bus_rvalid) state_nx = DONE;
            DONE:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        bus_req  = 1'b0;
        bus_we   = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    stall    = access & ~mis;
                    misalign = mis;
                end
                REQ: begin
                    stall   = 1'b1;
                    bus_req = 1'b1;
                    bus_we  = op_ctrl[3];
                end
                WAIT_R: stall = 1'b1;
                DONE:   ;
            endcase
        end
    end

    // Operands are frozen when leaving IDLE so the bus sees stable
    // values for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ctrl   <= MC_LB;
            op_off    <= 2'b00;
            bus_addr  <= 32'h0;
            bus_be    <= BE_NONE;
            bus_wdata <= 32'h0;
        end else if (issue) begin
            op_ctrl   <= in_ctrl;
            op_off    <= addr[1:0];
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= in_ctrl[3] ? st_be : BE_WORD;
            bus_wdata <= st_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= 32'h0;
        else if (capture)
            rdata <= ld_data;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues accesses and
// pushes model results, a negedge monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r, mem_w;
    logic [3:0]  mem_ctrl;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .mem_ctrl   (mem_ctrl),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        bit          mis;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    // Reference behaviour: size/sign from the access code, lanes from
    // byte arithmetic on the address.
    function automatic exp_t model(bit w, logic [3:0] c, logic [31:0] a,
                                   logic [31:0] wd, logic [31:0] rw, int lat);
        exp_t e;
        bit ok, uns;
        int size, off, nb;
        logic [31:0] v;
        if (w)
            ok = (c[3] == 1'b1) && (c[2:0] inside {3'd0, 3'd1, 3'd2});
        else
            ok = (c[3] == 1'b0) &&
                 (c[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = ok ? int'(c[1:0]) : 2;
        uns  = ok && c[2];
        off  = int'(a[1:0]);
        e.mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        e.mis = (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
`endif
        if (size == 1) off = off - (off % 2);
        if (size == 2) off = 0;
        nb = 1 << size;
        e.st   = w;
        e.addr = a - 32'(a % 4);
        e.be   = w ? 4'(((1 << nb) - 1) << off) : 4'hF;
        if (size == 0)      e.wd = {4{wd[7:0]}};
        else if (size == 1) e.wd = {2{wd[15:0]}};
        else                e.wd = wd;
        v = rw >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end
        e.rd  = v;
        e.lat = lat;
        return e;
    endfunction

    task automatic do_access(bit r, bit w, logic [3:0] c, logic [31:0] a,
                             logic [31:0] wd, logic [31:0] rw, int g, int k);
        exp_t e;
        int gl, kl, budget;
        bit granted;
        e = model(w, c, a, wd, rw, 2 + g + (w ? 0 : k));
        @(posedge clk); #1;
        mem_r = r; mem_w = w; mem_ctrl = c; addr = a; wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        sbq.push_back(e);
        if (e.mis) begin
            @(posedge clk); #1;
            mem_r = 1'b0; mem_w = 1'b0;
            return;
        end
        gl = g; kl = k; granted = 1'b0; budget = 0;
        forever begin
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (!stall) break;
            budget++;
            if (budget > 40) begin
                chk("timeout", 32'(stall), 32'd0);
                break;
            end
            if (bus_req) begin
                if (gl == 0) begin
                    bus_gnt = 1'b1;
                    granted = 1'b1;
                    if (!w && k == 0) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = rw;
                    end
                end else gl--;
            end else if (granted && !w) begin
                kl--;
                if (kl == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rw;
                end
            end
        end
        mem_r = 1'b0; mem_w = 1'b0;
        mem_ctrl = 4'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    int          stall_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] last_rd = 32'h0;

    always @(negedge clk) begin
        exp_t f;
        if (mon_en) begin
            if (misalign) begin
                if (sbq.size() != 0 && sbq[0].mis) begin
                    f = sbq.pop_front();
                    chk("trap_stall", 32'(stall), 32'd0);
                    chk("trap_req", 32'(bus_req), 32'd0);
                end else chk("misalign", 32'(misalign), 32'd0);
            end else if (sbq.size() != 0 && sbq[0].mis) begin
                f = sbq.pop_front();
                chk("misalign", 32'(misalign), 32'd1);
            end
            if (stall) stall_cnt++;
            if (bus_req && bus_gnt) begin
                if (sbq.size() == 0) chk("spurious_req", 32'(bus_req), 32'd0);
                else begin
                    chk("bus_addr", bus_addr, sbq[0].addr);
                    chk("bus_be", 32'(bus_be), 32'(sbq[0].be));
                    chk("bus_we", 32'(bus_we), 32'(sbq[0].st));
                    if (sbq[0].st) chk("bus_wdata", bus_wdata, sbq[0].wd);
                end
            end
            if (prev_stall && !stall) begin
                if (sbq.size() == 0) chk("spurious_done", 32'(stall), 32'd1);
                else begin
                    f = sbq.pop_front();
                    chk("latency", 32'(stall_cnt), 32'(f.lat));
                    if (!f.st) last_rd = f.rd;
                end
                stall_cnt = 0;
            end
            chk("rdata", rdata, last_rd);
            prev_stall = stall;
        end
    end

    logic [3:0] codes [8];

    initial begin
        bit r, w;
        logic [3:0] c;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                  4'b0101, 4'b1000, 4'b1001, 4'b1010};
        rst = 1'b1;
        mem_r = 0; mem_w = 0; mem_ctrl = 0; addr = 0; wdata = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // reset while waiting for read data abandons the load
        @(posedge clk); #1;
        mem_r = 1'b1; mem_ctrl = 4'b0000; addr = 32'h103;
        @(posedge clk); #1;
        chk("req_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; mem_r = 1'b0;
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_req", 32'(bus_req), 32'd0);
        rst = 1'b1;
        #2;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_be", 32'(bus_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h8000_0000;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_req", 32'(bus_req), 32'd0);

        mon_en = 1'b1;
        do_access(0, 1, 4'b1010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_access(1, 0, 4'b0000, 32'h103, 32'h0, 32'h8000_0000, 0, 2);
        do_access(1, 0, 4'b0101, 32'h102, 32'h0, 32'hABCD_1234, 0, 0);
        do_access(0, 1, 4'b1000, 32'h101, 32'h5A, 32'h0, 0, 0);
        do_access(1, 0, 4'b0010, 32'h102, 32'h0, 32'h1357_9BDF, 1, 1);
        do_access(0, 1, 4'b1001, 32'h203, 32'h1234_5678, 32'h0, 2, 0);
        do_access(1, 1, 4'b1000, 32'h302, 32'hA5C3, 32'h0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            c = codes[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) c = 4'($urandom);
            w = c[3];
            r = !c[3];
            if ($urandom_range(0, 7) == 0) begin
                r = 1'b1;
                w = 1'b1;
            end
            do_access(r, w, c, $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                @(posedge clk); #1;
                bus_rvalid = 1'($urandom_range(0, 1));
                bus_rdata  = $urandom;
            end
        end
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
